mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the core and merges its three memory masters onto one single-ported memory/interconnect port.
- The three masters are the instruction read bus, the data read bus and the data write bus.
- Only one transaction is outstanding at a time.
- Grants are fixed-priority: data write, then data read, then instruction read. A starvation counter guarantees the fetch path progresses.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width. Fixed at 32 for rv32i; the strobe is DATA_W/8 bits.
- STARVE_LIMIT, 4, number of consecutive data grants made while an instruction request is pending; the next grant is then forced to instruction. Range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_req  in  1  instruction read request; held until inst_ready.
- inst_addr  in  ADDR_W  instruction address; stable while inst_req.
- inst_ready  out  1  one-cycle pulse; inst_rdata valid.
- inst_rdata  out  DATA_W  instruction word.
- drd_req  in  1  data read request; held until drd_ready.
- drd_addr  in  ADDR_W  data read address.
- drd_ready  out  1  one-cycle pulse; drd_rdata valid.
- drd_rdata  out  DATA_W  read data.
- dwr_req  in  1  data write request; held until dwr_ready.
- dwr_addr  in  ADDR_W  write address.
- dwr_wdata  in  DATA_W  write data.
- dwr_wstrb  in  DATA_W/8  byte enables.
- dwr_ready  out  1  one-cycle pulse; write complete.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte enables; 0 on reads.
- mem_ready  in  1  one-cycle completion pulse from memory; may occur in the same cycle mem_req first rises.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.

Behaviour:
- Reset (rst_n low, asynchronous) clears the following, and reset mid-transaction abandons the access without any ready pulse:
  - all outputs to 0;
  - state to IDLE;
  - starvation counter to 0.
- States: IDLE, BUSY, RESP.
- IDLE: sample requests and pick a winner.
  - Winner order: dwr > drd > inst.
  - Override: if inst_req is high and starve_cnt == STARVE_LIMIT, inst wins regardless of data requests.
  - On a winner: register grant id; register mem_addr, mem_we, mem_wdata and mem_wstrb from the winner; set mem_req = 1; go to BUSY.
  - No request: stay in IDLE with mem_req = 0.
- BUSY: mem_req and all mem_* outputs are held stable.
  - On mem_ready: mem_req = 0; capture mem_rdata into the winner's rdata register (reads only); assert the winner's ready for exactly the next cycle; go to RESP.
- RESP: the winner's ready is high for this single cycle and the matching rdata is valid.
  - Requests are not sampled in RESP, so a master dropping req at the end of RESP is never re-granted. Next state is IDLE.
- rdata registers hold their value until the next capture for the same master. Non-winning ready outputs stay 0.
- Latency: a request first seen in IDLE at cycle 0 gives mem_req in cycle 1. mem_ready in cycle N (N ≥ 1) gives master ready in cycle N+1.
  - Minimum is 2 cycles, at most one transaction per 3 cycles.
- Starvation counter, updated on each grant in IDLE:
  - data winner while inst_req high: saturating increment;
  - inst winner: clear to 0;
  - data winner with inst_req low: clear to 0.
- Simultaneous requests: exactly one grant per IDLE cycle; losers keep req high and are served in later IDLE cycles.
- Request inputs changing while not in IDLE are ignored. Masters must not withdraw req before ready; behaviour if they do is undefined.
- mem_ready arriving in IDLE or RESP is ignored.

Test Plan:
- Single inst read, zero-wait memory (mem_ready in the first mem_req cycle), inst_addr=0x100, mem_rdata=0x00000013 -> mem_req high only cycle 1, mem_we=0; inst_ready pulse cycle 2 with inst_rdata=0x00000013.
- Write with 3-cycle memory wait, dwr_addr=0x2000, wdata=0xDEADBEEF, wstrb=4'b0011 -> mem_we=1 and mem_wstrb=4'b0011 held stable across all mem_req cycles; dwr_ready single pulse the cycle after mem_ready.
- Same-cycle dwr_req, drd_req and inst_req -> grant order write, read, inst; each ready pulses once with correct data; no overlapping mem_req.
- inst_req held while drd_req is reissued continuously, STARVE_LIMIT=4 -> 4 data grants, then the 5th grant goes to inst; counter then returns to 0.
- rst_n asserted low in BUSY mid-wait -> outputs 0 immediately (asynchronous), no ready pulse; after release, a fresh drd request completes normally.
- mem_ready pulsed while in IDLE with no request -> no state change and no ready outputs.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Merges the core's instruction-read, data-read and data-write buses onto one memory port.
// One transaction in flight at a time; fixed priority dwr > drd > inst with a fetch anti-starvation override.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_ready,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                drd_req,
    input  logic [ADDR_W-1:0]   drd_addr,
    output logic                drd_ready,
    output logic [DATA_W-1:0]   drd_rdata,

    input  logic                dwr_req,
    input  logic [ADDR_W-1:0]   dwr_addr,
    input  logic [DATA_W-1:0]   dwr_wdata,
    input  logic [DATA_W/8-1:0] dwr_wstrb,
    output logic                dwr_ready,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_t;

    typedef enum logic [1:0] {
        GntInst,
        GntDrd,
        GntDwr
    } gnt_t;

    state_t     state;
    gnt_t       gnt;
    gnt_t       pick;
    logic       pick_valid;
    logic       starved;
    logic [3:0] starve_cnt;

    // Winner selection for the current IDLE cycle.
    always_comb begin
        starved    = inst_req && (starve_cnt == STARVE_MAX);
        pick_valid = inst_req || drd_req || dwr_req;
        pick       = GntInst;
        if (starved) begin
            pick = GntInst;
        end else if (dwr_req) begin
            pick = GntDwr;
        end else if (drd_req) begin
            pick = GntDrd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            gnt        <= GntInst;
            starve_cnt <= 4'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            inst_ready <= 1'b0;
            drd_ready  <= 1'b0;
            dwr_ready  <= 1'b0;
            inst_rdata <= '0;
            drd_rdata  <= '0;
        end else begin
            // Ready outputs are single-cycle pulses unless set below.
            inst_ready <= 1'b0;
            drd_ready  <= 1'b0;
            dwr_ready  <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        gnt     <= pick;
                        mem_req <= 1'b1;
                        state   <= StBusy;

                        unique case (pick)
                            GntDwr: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= dwr_addr;
                                mem_wdata <= dwr_wdata;
                                mem_wstrb <= dwr_wstrb;
                            end
                            GntDrd: begin
                                mem_we    <= 1'b0;
                                mem_addr  <= drd_addr;
                                mem_wdata <= '0;
                                mem_wstrb <= '0;
                            end
                            default: begin
                                mem_we    <= 1'b0;
                                mem_addr  <= inst_addr;
                                mem_wdata <= '0;
                                mem_wstrb <= '0;
                            end
                        endcase

                        // Count data grants that bypassed a waiting fetch.
                        if (pick != GntInst && inst_req) begin
                            if (starve_cnt != STARVE_MAX) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            starve_cnt <= 4'd0;
                        end
                    end
                end

                StBusy: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= StResp;
                        unique case (gnt)
                            GntDwr: begin
                                dwr_ready <= 1'b1;
                            end
                            GntDrd: begin
                                drd_ready <= 1'b1;
                                drd_rdata <= mem_rdata;
                            end
                            default: begin
                                inst_ready <= 1'b1;
                                inst_rdata <= mem_rdata;
                            end
                        endcase
                    end
                end

                StResp: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
